// File: rtl/pcd8544_spi_receiver.sv
// pcd8544_spi_receiver
//   Responder end of a PCD8544 (Nokia 5110) SPI link. Oversamples the SPI pins
//   with clk_main, assembles MSB-first bytes, decodes controller commands and
//   emits frame-buffer writes using the controller's auto-increment addressing.
//
// Ports
//   clk_main, rst_n       system clock, asynchronous active-low reset
//   spi_sce/clk/mosi/d_c  SPI pins (asynchronous, synchronised internally)
//   scr_rst_n             screen RST pin (asynchronous, synchronised, clears state)
//   fb_wr_en/addr/data    one-cycle frame buffer write (addr = y*COLS + x)
//   cmd_valid/cmd_byte    one-cycle pulse per command byte and the byte itself
//   pos_x/pos_y           current column / bank pointer
//   power_down, vertical, ext_instr, disp_mode, vop, bias, temp_coef
//                         decoded controller configuration
module pcd8544_spi_receiver #(
    parameter int unsigned COLS   = 84,
    parameter int unsigned BANKS  = 6,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_main,
    input  logic              rst_n,
    input  logic              spi_sce,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_d_c,
    input  logic              scr_rst_n,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic [6:0]        pos_x,
    output logic [2:0]        pos_y,
    output logic              power_down,
    output logic              vertical,
    output logic              ext_instr,
    output logic [1:0]        disp_mode,
    output logic [6:0]        vop,
    output logic [2:0]        bias,
    output logic [1:0]        temp_coef
);

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [2:0] Y_LAST = 3'(BANKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EXEC} state_t;

    // Input synchronisers and SCLK edge detection
    logic [1:0] sce_sync_q, sclk_sync_q, mosi_sync_q, dc_sync_q, srst_sync_q;
    logic       sclk_prev_q, rise_q, mosi_cap_q, dc_cap_q;

    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            sce_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            srst_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            mosi_cap_q  <= 1'b0;
            dc_cap_q    <= 1'b0;
        end else begin
            sce_sync_q  <= {sce_sync_q[0], spi_sce};
            sclk_sync_q <= {sclk_sync_q[0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            dc_sync_q   <= {dc_sync_q[0], spi_d_c};
            srst_sync_q <= {srst_sync_q[0], scr_rst_n};
            sclk_prev_q <= sclk_sync_q[1];
            // Edge flag is registered together with the MOSI/D_C values seen
            // at the edge so they stay aligned with the shift that uses them.
            rise_q      <= sclk_sync_q[1] & ~sclk_prev_q;
            mosi_cap_q  <= mosi_sync_q[1];
            dc_cap_q    <= dc_sync_q[1];
        end
    end

    // Receive FSM and decoded state
    state_t            state_q;
    logic [2:0]        bitcnt_q;
    logic [7:0]        shift_q;
    logic              dc_q;
    logic              fb_wr_en_q, cmd_valid_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [7:0]        fb_data_q, cmd_byte_q;
    logic [6:0]        pos_x_q, vop_q;
    logic [2:0]        pos_y_q, bias_q;
    logic              pd_q, vert_q, ext_q;
    logic [1:0]        disp_q, temp_q;

    // Auto-increment next position and current write address
    logic [6:0]        x_inc_d, pos_x_d;
    logic [2:0]        y_inc_d, pos_y_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        x_inc_d = (pos_x_q == X_LAST) ? '0 : pos_x_q + 7'd1;
        y_inc_d = (pos_y_q == Y_LAST) ? '0 : pos_y_q + 3'd1;
        if (!vert_q) begin
            pos_x_d = x_inc_d;
            pos_y_d = (pos_x_q == X_LAST) ? y_inc_d : pos_y_q;
        end else begin
            pos_y_d = y_inc_d;
            pos_x_d = (pos_y_q == Y_LAST) ? x_inc_d : pos_x_q;
        end
        addr_d = ADDR_W'(pos_y_q) * ADDR_W'(COLS) + ADDR_W'(pos_x_q);
    end

    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            dc_q        <= 1'b0;
            fb_wr_en_q  <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pd_q        <= 1'b1;
            vert_q      <= 1'b0;
            ext_q       <= 1'b0;
            disp_q      <= '0;
            vop_q       <= '0;
            bias_q      <= '0;
            temp_q      <= '0;
        end else if (!srst_sync_q[1]) begin
            // Screen reset wins over everything, including an EXEC cycle.
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            dc_q        <= 1'b0;
            fb_wr_en_q  <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pd_q        <= 1'b1;
            vert_q      <= 1'b0;
            ext_q       <= 1'b0;
            disp_q      <= '0;
            vop_q       <= '0;
            bias_q      <= '0;
            temp_q      <= '0;
        end else begin
            fb_wr_en_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!sce_sync_q[1]) begin
                        state_q  <= S_SHIFT;
                        bitcnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    if (sce_sync_q[1]) begin
                        state_q  <= S_IDLE;
                        bitcnt_q <= '0;
                        shift_q  <= '0;
                    end else if (rise_q) begin
                        shift_q  <= {shift_q[6:0], mosi_cap_q};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            dc_q    <= dc_cap_q;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    state_q <= sce_sync_q[1] ? S_IDLE : S_SHIFT;
                    if (dc_q) begin
                        fb_wr_en_q <= 1'b1;
                        fb_addr_q  <= addr_d;
                        fb_data_q  <= shift_q;
                        pos_x_q    <= pos_x_d;
                        pos_y_q    <= pos_y_d;
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_byte_q  <= shift_q;
                        if (shift_q[7:3] == 5'b00100) begin
                            pd_q   <= shift_q[2];
                            vert_q <= shift_q[1];
                            ext_q  <= shift_q[0];
                        end else if (!ext_q) begin
                            if (shift_q[7]) begin
                                if (shift_q[6:0] <= X_LAST) pos_x_q <= shift_q[6:0];
                            end else if (shift_q[7:3] == 5'b01000) begin
                                if (shift_q[2:0] <= Y_LAST) pos_y_q <= shift_q[2:0];
                            end else if (shift_q[7:3] == 5'b00001 && !shift_q[1]) begin
                                disp_q <= {shift_q[2], shift_q[0]};
                            end
                        end else begin
                            if (shift_q[7]) begin
                                vop_q <= shift_q[6:0];
                            end else if (shift_q[7:3] == 5'b00010) begin
                                bias_q <= shift_q[2:0];
                            end else if (shift_q[7:2] == 6'b000001) begin
                                temp_q <= shift_q[1:0];
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_wr_en   = fb_wr_en_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign power_down = pd_q;
    assign vertical   = vert_q;
    assign ext_instr  = ext_q;
    assign disp_mode  = disp_q;
    assign vop        = vop_q;
    assign bias       = bias_q;
    assign temp_coef  = temp_q;

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// tb_pcd8544_spi_receiver
//   Directed bench for pcd8544_spi_receiver. Drives SPI bytes at two SCLK
//   rates (clk_main/4 and clk_main/8) and checks decoded registers, frame
//   buffer writes and strobe latency against hand-computed values.
module tb_pcd8544_spi_receiver;

    logic       clk_main = 1'b0;
    logic       rst_n, spi_sce, spi_clk, spi_mosi, spi_d_c, scr_rst_n;
    logic       fb_wr_en, cmd_valid;
    logic [8:0] fb_addr;
    logic [7:0] fb_data, cmd_byte;
    logic [6:0] pos_x, vop;
    logic [2:0] pos_y, bias;
    logic       power_down, vertical, ext_instr;
    logic [1:0] disp_mode, temp_coef;

    pcd8544_spi_receiver #(.COLS(84), .BANKS(6), .ADDR_W(9)) dut (
        .clk_main  (clk_main),
        .rst_n     (rst_n),
        .spi_sce   (spi_sce),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_d_c   (spi_d_c),
        .scr_rst_n (scr_rst_n),
        .fb_wr_en  (fb_wr_en),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .power_down(power_down),
        .vertical  (vertical),
        .ext_instr (ext_instr),
        .disp_mode (disp_mode),
        .vop       (vop),
        .bias      (bias),
        .temp_coef (temp_coef)
    );

    always #5 clk_main = ~clk_main;

    // Strobe log, sampled on the falling edge away from the active edge
    int wr_addr_log[$];
    int wr_data_log[$];
    int cmd_log[$];

    always @(negedge clk_main) begin
        if (fb_wr_en) begin
            wr_addr_log.push_back(int'(fb_addr));
            wr_data_log.push_back(int'(fb_data));
        end
        if (cmd_valid) cmd_log.push_back(int'(cmd_byte));
    end

    int checks   = 0;
    int failures = 0;
    int half     = 2;
    int n_wr, n_cmd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_main);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            spi_clk  = 1'b0;
            tick(half);
            spi_clk  = 1'b1;
            tick(half);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        spi_d_c = dc;
        send_bits(b, 8);
        spi_clk = 1'b0;
        tick(half + 6);
    endtask

    // Sends a data byte and checks the write strobe rises exactly four clk_main
    // edges after the first edge that samples the 8th SCLK high.
    task automatic send_byte_lat(input logic [7:0] b, input int exp_addr);
        spi_d_c = 1'b1;
        send_bits(b, 7);
        spi_mosi = b[0];
        spi_clk  = 1'b0;
        tick(half);
        spi_clk  = 1'b1;
        @(posedge clk_main);
        repeat (3) @(posedge clk_main);
        #1 chk("lat_e3_low", 32'(fb_wr_en), 32'd0);
        @(posedge clk_main);
        #1 chk("lat_e4_high", 32'(fb_wr_en), 32'd1);
        chk("lat_addr", 32'(fb_addr), 32'(exp_addr));
        chk("lat_data", 32'(fb_data), 32'(b));
        @(posedge clk_main);
        #1 chk("lat_e5_low", 32'(fb_wr_en), 32'd0);
        @(negedge clk_main);
        spi_clk = 1'b0;
        tick(half + 6);
    endtask

    task automatic sce_begin();
        spi_sce = 1'b0;
        tick(4);
    endtask

    task automatic sce_end();
        tick(4);
        spi_sce = 1'b1;
        tick(6);
    endtask

    initial begin
        rst_n = 1'b0; scr_rst_n = 1'b1; spi_sce = 1'b1;
        spi_clk = 1'b0; spi_mosi = 1'b0; spi_d_c = 1'b0;

        for (int p = 0; p < 2; p++) begin
            half = (p == 0) ? 2 : 4;

            // Reset then idle
            rst_n = 1'b0;
            tick(3);
            rst_n = 1'b1;
            n_wr  = wr_addr_log.size();
            n_cmd = cmd_log.size();
            tick(1000);
            chk("idle_writes", 32'(wr_addr_log.size() - n_wr), 32'd0);
            chk("idle_cmds", 32'(cmd_log.size() - n_cmd), 32'd0);
            chk("rst_power_down", 32'(power_down), 32'd1);
            chk("rst_pos", {22'd0, pos_y, pos_x}, 32'd0);
            chk("rst_cfg", {14'd0, vertical, ext_instr, disp_mode, vop, bias, temp_coef}, 32'd0);
            chk("rst_fb", {15'd0, fb_addr, fb_data}, 32'd0);
            chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);

            // Configuration command sequence in one sce window
            n_cmd = cmd_log.size();
            sce_begin();
            send_byte(8'h21, 1'b0);
            send_byte(8'hBF, 1'b0);
            send_byte(8'h14, 1'b0);
            send_byte(8'h04, 1'b0);
            send_byte(8'h20, 1'b0);
            send_byte(8'h0C, 1'b0);
            sce_end();
            chk("cfg_cmd_count", 32'(cmd_log.size() - n_cmd), 32'd6);
            chk("cfg_cmd_first", 32'(cmd_log[n_cmd]), 32'h21);
            chk("cfg_cmd_last", 32'(cmd_log[n_cmd+5]), 32'h0C);
            chk("cfg_vop", 32'(vop), 32'h3F);
            chk("cfg_bias", 32'(bias), 32'd4);
            chk("cfg_temp", 32'(temp_coef), 32'd0);
            chk("cfg_ext", 32'(ext_instr), 32'd0);
            chk("cfg_pd", 32'(power_down), 32'd0);
            chk("cfg_disp", 32'(disp_mode), 32'd2);

            // Horizontal wrap at the last position
            n_wr = wr_addr_log.size();
            sce_begin();
            send_byte(8'hD3, 1'b0);
            send_byte(8'h45, 1'b0);
            chk("hpos_set", {22'd0, pos_y, pos_x}, {22'd0, 3'd5, 7'd83});
            send_byte(8'hAA, 1'b1);
            send_byte_lat(8'h55, 0);
            sce_end();
            chk("h_wr_count", 32'(wr_addr_log.size() - n_wr), 32'd2);
            chk("h_wr0_addr", 32'(wr_addr_log[n_wr]), 32'd503);
            chk("h_wr0_data", 32'(wr_data_log[n_wr]), 32'hAA);
            chk("h_wr1_addr", 32'(wr_addr_log[n_wr+1]), 32'd0);
            chk("h_wr1_data", 32'(wr_data_log[n_wr+1]), 32'h55);
            chk("h_pos_x", 32'(pos_x), 32'd1);
            chk("h_pos_y", 32'(pos_y), 32'd0);

            // Vertical addressing with bank wrap
            n_wr = wr_addr_log.size();
            sce_begin();
            send_byte(8'h22, 1'b0);
            send_byte(8'h8A, 1'b0);
            send_byte(8'h45, 1'b0);
            send_byte(8'h01, 1'b1);
            send_byte(8'h02, 1'b1);
            sce_end();
            chk("v_mode", 32'(vertical), 32'd1);
            chk("v_wr_count", 32'(wr_addr_log.size() - n_wr), 32'd2);
            chk("v_wr0", {wr_addr_log[n_wr][15:0], wr_data_log[n_wr][15:0]}, {16'd430, 16'h01});
            chk("v_wr1", {wr_addr_log[n_wr+1][15:0], wr_data_log[n_wr+1][15:0]}, {16'd11, 16'h02});
            chk("v_pos", {22'd0, pos_y, pos_x}, {22'd0, 3'd1, 7'd11});

            // Out-of-range Y and X
            n_cmd = cmd_log.size();
            sce_begin();
            send_byte(8'h47, 1'b0);
            send_byte(8'hD4, 1'b0);
            sce_end();
            chk("oor_cmd_count", 32'(cmd_log.size() - n_cmd), 32'd2);
            chk("oor_pos", {22'd0, pos_y, pos_x}, {22'd0, 3'd1, 7'd11});

            // Abort after five bits, then a full data byte
            n_wr = wr_addr_log.size();
            sce_begin();
            spi_d_c = 1'b1;
            send_bits(8'hFF, 5);
            spi_clk = 1'b0;
            spi_sce = 1'b1;
            tick(6);
            sce_begin();
            send_byte(8'hF0, 1'b1);
            sce_end();
            chk("abort_wr_count", 32'(wr_addr_log.size() - n_wr), 32'd1);
            chk("abort_wr_data", 32'(wr_data_log[n_wr]), 32'hF0);
            chk("abort_wr_addr", 32'(wr_addr_log[n_wr]), 32'd95);
            chk("abort_pos", {22'd0, pos_y, pos_x}, {22'd0, 3'd2, 7'd11});

            // Screen reset in the middle of a byte
            n_wr = wr_addr_log.size();
            sce_begin();
            send_bits(8'hFF, 3);
            spi_clk   = 1'b0;
            scr_rst_n = 1'b0;
            tick(4);
            scr_rst_n = 1'b1;
            tick(4);
            chk("srst_pd", 32'(power_down), 32'd1);
            chk("srst_pos", {22'd0, pos_y, pos_x}, 32'd0);
            chk("srst_cfg", {14'd0, vertical, ext_instr, disp_mode, vop, bias, temp_coef}, 32'd0);
            send_byte(8'h3C, 1'b1);
            sce_end();
            chk("srst_wr_count", 32'(wr_addr_log.size() - n_wr), 32'd1);
            chk("srst_wr", {wr_addr_log[n_wr][15:0], wr_data_log[n_wr][15:0]}, {16'd0, 16'h3C});
            chk("srst_pos_x", 32'(pos_x), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
